// File: rtl/wb_write_queue_if.sv
// ============================================================================
//  Module      : wb_write_queue_if
//  Description : MUL/DIV result handshake into the writeback queue.
//                master = MUL/DIV result producer, slave = wb_write_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_write_queue_if;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_dest;
    logic [31:0] md_wdata;

    modport master (output md_valid, output md_dest, output md_wdata, input md_ready);
    modport slave  (input md_valid, input md_dest, input md_wdata, output md_ready);
endinterface

`default_nettype wire

// File: rtl/wb_write_queue.sv
// ============================================================================
//  Module      : wb_write_queue
//  Description : Owner of the single regfile write port. Pipeline WB writes
//                take priority; MUL/DIV results are buffered in a FIFO and
//                drained into free slots. A pending-register scoreboard
//                reports outstanding multi-cycle destinations to decode, and
//                a starvation counter requests a pipeline freeze when the
//                FIFO head has been blocked for STARVE_LIM cycles.
//                Optional macro WBQ_BYPASS_EN adds FIFO-to-decode forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_write_queue #(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 4
) (
    input  wire                         clk,
    input  wire                         rst_n,
    input  wire                         i_alu_we,
    input  wire  [4:0]                  i_alu_dest,
    input  wire  [31:0]                 i_alu_wdata,
    wb_write_queue_if.slave             md,
    input  wire                         i_issue_valid,
    input  wire  [4:0]                  i_issue_dest,
    input  wire  [4:0]                  i_chk_addr1,
    input  wire  [4:0]                  i_chk_addr2,
    output logic                        o_busy1,
    output logic                        o_busy2,
    output logic                        o_wb_stall,
    output logic                        o_rf_write,
    output logic [4:0]                  o_rf_dest,
    output logic [31:0]                 o_rf_wdata,
    output logic [$clog2(DEPTH):0]      o_count
`ifdef WBQ_BYPASS_EN
    ,
    output logic                        o_fwd_hit1,
    output logic                        o_fwd_hit2,
    output logic [31:0]                 o_fwd_data1,
    output logic [31:0]                 o_fwd_data2
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [4:0]    r_mem_dest [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_pending;

    logic          w_empty;
    logic          w_alu_take;
    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_set;
    logic [31:0]   w_clr;

    // Pipeline writes own the slot (r0 writes are dropped); FIFO head fills any free slot.
    assign w_empty    = (r_count == '0);
    assign w_alu_take = rst_n && i_alu_we && (i_alu_dest != 5'd0);
    assign w_pop      = !w_alu_take && !w_empty;
    assign md.md_ready = (r_count != CW'(DEPTH));
    // Results to r0 complete the handshake but are never enqueued.
    assign w_push     = md.md_valid && md.md_ready && (md.md_dest != 5'd0);

    assign o_rf_write = w_alu_take || w_pop;
    assign o_rf_dest  = w_alu_take ? i_alu_dest  : (w_pop ? r_mem_dest[r_rptr] : 5'd0);
    assign o_rf_wdata = w_alu_take ? i_alu_wdata : (w_pop ? r_mem_data[r_rptr] : 32'd0);
    assign o_count    = r_count;
    assign o_wb_stall = (r_starve == SW'(STARVE_LIM));

    // FIFO storage: data only, no reset needed since occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dest[r_wptr] <= md.md_dest;
            r_mem_data[r_wptr] <= md.md_wdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Starvation counter: counts cycles the head is blocked by a pipeline write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_pop || w_empty) begin
            r_starve <= '0;
        end else if (r_starve != SW'(STARVE_LIM)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Scoreboard set/clear decode; r0 is never tracked.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_issue_valid && (i_issue_dest != 5'd0)) w_set[i_issue_dest] = 1'b1;
        if (w_pop) w_clr[r_mem_dest[r_rptr]] = 1'b1;
    end

    // Pending bits: a new issue overrides a same-cycle drain of that register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr) | w_set) & 32'hFFFF_FFFE;
        end
    end

`ifdef WBQ_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    // Scan oldest to youngest so the last match (youngest entry) wins.
    always_comb begin
        w_hit1      = 1'b0;
        w_hit2      = 1'b0;
        o_fwd_data1 = 32'd0;
        o_fwd_data2 = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < r_count) begin
                if ((i_chk_addr1 != 5'd0) && (r_mem_dest[r_rptr + AW'(k)] == i_chk_addr1)) begin
                    w_hit1      = 1'b1;
                    o_fwd_data1 = r_mem_data[r_rptr + AW'(k)];
                end
                if ((i_chk_addr2 != 5'd0) && (r_mem_dest[r_rptr + AW'(k)] == i_chk_addr2)) begin
                    w_hit2      = 1'b1;
                    o_fwd_data2 = r_mem_data[r_rptr + AW'(k)];
                end
            end
        end
    end

    assign o_fwd_hit1 = w_hit1;
    assign o_fwd_hit2 = w_hit2;
    // A forwarded value replaces the stall.
    assign o_busy1    = r_pending[i_chk_addr1] && !w_hit1;
    assign o_busy2    = r_pending[i_chk_addr2] && !w_hit2;
`else
    // Busy holds until the queued result is written to the regfile.
    assign o_busy1    = r_pending[i_chk_addr1];
    assign o_busy2    = r_pending[i_chk_addr2];
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_write_queue.sv
// ============================================================================
//  Module      : tb_wb_write_queue
//  Description : Self-checking bench for wb_write_queue: a table of per-cycle
//                input/expected-output records plus hand-written sequences
//                for reset, bypass forwarding and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_write_queue;

    logic        clk;
    logic        rst_n;
    logic        alu_we;
    logic [4:0]  alu_dest;
    logic [31:0] alu_wdata;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic [4:0]  chk1;
    logic [4:0]  chk2;
    logic        busy1;
    logic        busy2;
    logic        wb_stall;
    logic        rf_write;
    logic [4:0]  rf_dest;
    logic [31:0] rf_wdata;
    logic [2:0]  count;
`ifdef WBQ_BYPASS_EN
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    wb_write_queue_if mdif ();

    wb_write_queue #(.DEPTH(4), .STARVE_LIM(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alu_we     (alu_we),
        .i_alu_dest   (alu_dest),
        .i_alu_wdata  (alu_wdata),
        .md           (mdif),
        .i_issue_valid(issue_valid),
        .i_issue_dest (issue_dest),
        .i_chk_addr1  (chk1),
        .i_chk_addr2  (chk2),
        .o_busy1      (busy1),
        .o_busy2      (busy2),
        .o_wb_stall   (wb_stall),
        .o_rf_write   (rf_write),
        .o_rf_dest    (rf_dest),
        .o_rf_wdata   (rf_wdata),
        .o_count      (count)
`ifdef WBQ_BYPASS_EN
        ,
        .o_fwd_hit1   (fwd_hit1),
        .o_fwd_hit2   (fwd_hit2),
        .o_fwd_data1  (fwd_data1),
        .o_fwd_data2  (fwd_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        aw;   logic [4:0] ad;  logic [31:0] awd;
        logic        mv;   logic [4:0] md;  logic [31:0] mwd;
        logic        iv;   logic [4:0] id;
        logic [4:0]  c1;   logic [4:0] c2;
        logic        rfw;  logic [4:0] rfd; logic [31:0] rfdat;
        logic        rdy;  logic [2:0] cnt;
        logic        b1;   logic       b2;  logic        st;
        logic        q1;   logic       q2;   // chk address present in FIFO (bypass masks busy)
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic aw, input logic [4:0] ad, input logic [31:0] awd,
                         input logic mv, input logic [4:0] mdst, input logic [31:0] mwd,
                         input logic iv, input logic [4:0] id,
                         input logic [4:0] c1, input logic [4:0] c2);
        alu_we = aw; alu_dest = ad; alu_wdata = awd;
        mdif.md_valid = mv; mdif.md_dest = mdst; mdif.md_wdata = mwd;
        issue_valid = iv; issue_dest = id; chk1 = c1; chk2 = c2;
    endtask

    // Packs the observable outputs; dest/data only meaningful when a write is expected.
    function automatic logic [79:0] pack_out(input logic rfw_exp);
        return {rf_write, (rfw_exp ? rf_dest : 5'd0), (rfw_exp ? rf_wdata : 32'd0),
                mdif.md_ready, count, busy1, busy2, wb_stall};
    endfunction

    initial begin
        //           aw ad  awd        mv md  mwd          iv id  c1  c2   rfw rfd rfdat        rdy cnt b1 b2 st q1 q2
        vecs[0]  = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd5,5'd0,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b1,5'd5, 5'd5,5'd0,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd5,5'd0,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b1,1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd5,5'd0,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b1,1'b0,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0,5'd0,32'h0,   1'b1,5'd5,32'h1234,  1'b0,5'd0, 5'd5,5'd0,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b1,1'b0,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd5,5'd0,  1'b1,5'd5,32'h1234,  1'b1,3'd1,1'b1,1'b0,1'b0,1'b1,1'b0};
        vecs[6]  = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd5,5'd0,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b1,5'd2,32'hA0,  1'b1,5'd10,32'h100,  1'b0,5'd0, 5'd10,5'd13,1'b1,5'd2,32'hA0,    1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b1,5'd2,32'hA1,  1'b1,5'd11,32'h101,  1'b0,5'd0, 5'd10,5'd13,1'b1,5'd2,32'hA1,    1'b1,3'd1,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b1,5'd2,32'hA2,  1'b1,5'd12,32'h102,  1'b0,5'd0, 5'd10,5'd13,1'b1,5'd2,32'hA2,    1'b1,3'd2,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b1,5'd2,32'hA3,  1'b1,5'd13,32'h103,  1'b0,5'd0, 5'd10,5'd13,1'b1,5'd2,32'hA3,    1'b1,3'd3,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[11] = '{1'b1,5'd2,32'hA4,  1'b1,5'd14,32'h104,  1'b0,5'd0, 5'd10,5'd13,1'b1,5'd2,32'hA4,    1'b0,3'd4,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b0,5'd0,32'h0,   1'b1,5'd14,32'h104,  1'b0,5'd0, 5'd10,5'd13,1'b1,5'd10,32'h100,  1'b0,3'd4,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b0,5'd0,32'h0,   1'b1,5'd14,32'h104,  1'b0,5'd0, 5'd10,5'd13,1'b1,5'd11,32'h101,  1'b1,3'd3,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[14] = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd0,5'd0,  1'b1,5'd12,32'h102,  1'b1,3'd3,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[15] = '{1'b0,5'd0,32'h0,   1'b1,5'd0,32'hDEAD,  1'b0,5'd0, 5'd0,5'd0,  1'b1,5'd13,32'h103,  1'b1,3'd2,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[16] = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd0,5'd0,  1'b1,5'd14,32'h104,  1'b1,3'd1,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[17] = '{1'b0,5'd0,32'h0,   1'b1,5'd0,32'hBEEF,  1'b0,5'd0, 5'd0,5'd0,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[18] = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd0,5'd0,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[19] = '{1'b0,5'd0,32'h0,   1'b1,5'd7,32'h77,    1'b1,5'd7, 5'd7,5'd0,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[20] = '{1'b1,5'd0,32'h55,  1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd7,5'd0,  1'b1,5'd7,32'h77,    1'b1,3'd1,1'b1,1'b0,1'b0,1'b1,1'b0};
        vecs[21] = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd7,5'd0,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[22] = '{1'b0,5'd0,32'h0,   1'b1,5'd9,32'h99,    1'b1,5'd9, 5'd0,5'd9,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[23] = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b1,5'd9, 5'd0,5'd9,  1'b1,5'd9,32'h99,    1'b1,3'd1,1'b0,1'b1,1'b0,1'b0,1'b1};
        vecs[24] = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd0,5'd9,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[25] = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b1,5'd0, 5'd0,5'd9,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[26] = '{1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd0,5'd9,  1'b0,5'd0,32'h0,     1'b1,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0};

        // Reset with a pipeline write presented: it must be ignored.
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'hFFFF_0000, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd3);
        repeat (2) @(negedge clk);
        #2;
        check("reset_state", pack_out(1'b0),
              {1'b0, 5'd0, 32'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            logic eb1, eb2;
            drive(vecs[i].aw, vecs[i].ad, vecs[i].awd, vecs[i].mv, vecs[i].md, vecs[i].mwd,
                  vecs[i].iv, vecs[i].id, vecs[i].c1, vecs[i].c2);
            eb1 = vecs[i].b1;
            eb2 = vecs[i].b2;
`ifdef WBQ_BYPASS_EN
            eb1 = eb1 && !vecs[i].q1;
            eb2 = eb2 && !vecs[i].q2;
`endif
            #2;
            check($sformatf("vec%0d", i), pack_out(vecs[i].rfw),
                  {vecs[i].rfw, vecs[i].rfd, vecs[i].rfdat, vecs[i].rdy, vecs[i].cnt,
                   eb1, eb2, vecs[i].st});
            @(negedge clk);
        end

        // Two results for r3 queued behind pipeline writes; decode probes r3.
        drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'hBB, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        #2;
`ifdef WBQ_BYPASS_EN
        check("bypass_hit", {fwd_hit1, fwd_data1, busy1, fwd_hit2},
              {1'b1, 32'hBB, 1'b0, 1'b0});
`else
        check("r3_queued", {count, busy1, busy2}, {3'd2, 1'b1, 1'b0});
`endif
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
        #2;
        check("drain_r3_aa", {rf_write, rf_dest, rf_wdata, busy1},
              {1'b1, 5'd3, 32'hAA, 1'b1});
        @(negedge clk);
        #2;
        check("drain_r3_bb", {rf_write, rf_dest, rf_wdata, count},
              {1'b1, 5'd3, 32'hBB, 3'd1});
        @(negedge clk);
        #2;
        check("r3_released", {rf_write, count, busy1}, {1'b0, 3'd0, 1'b0});

        // Reset mid-operation discards queued result and pending bits.
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h4, 1'b1, 5'd20, 32'h2020, 1'b1, 5'd20, 5'd20, 5'd9);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd9);
        #2;
        check("pre_reset", {count, busy1, busy2}, {3'd1, 1'b1, 1'b1});
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset", {rf_write, mdif.md_ready, count, busy1, busy2, wb_stall},
              {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd9);
        #2;
        check("post_reset", {rf_write, count, busy1, busy2}, {1'b0, 3'd0, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
